// File: rtl/sr_rf_pkg.sv
// sr_rf_pkg: default sizing and the hardwired-zero register index for the register file.
package sr_rf_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NREAD_DEF = 3;
   localparam int ZERO_REG  = 0;
endpackage

// File: rtl/sr_rf_scoreboard.sv
// sr_rf_scoreboard: per-register pending bits, set by reservation and cleared by port-1 writeback.
module sr_rf_scoreboard
   import sr_rf_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_a,
   output logic [NREGS-1:0] busy
);
   logic [NREGS-1:0] busy_n;
   // Reservation is applied after the clear so a same-cycle reserve wins.
   always_comb begin
      busy_n = busy;
      if (we1) busy_n[wa1] = 1'b0;
      if (rsv_en) busy_n[rsv_a] = 1'b1;
      busy_n[ZERO_REG] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else busy <= busy_n;
   end
endmodule

// File: rtl/sr_register_file_mp.sv
// sr_register_file_mp: multi-read, dual-write register file with x0 hardwired to zero,
// optional write-to-read forwarding and a reservation scoreboard.
module sr_register_file_mp
   import sr_rf_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREGS  = NREGS_DEF,
   parameter  int NREAD  = NREAD_DEF,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   ra,
   output logic [NREAD*XLEN-1:0] rd,
   output logic [NREAD-1:0]      rbusy,
   input  logic                  we0,
   input  logic [AW-1:0]         wa0,
   input  logic [XLEN-1:0]       wd0,
   input  logic                  we1,
   input  logic [AW-1:0]         wa1,
   input  logic [XLEN-1:0]       wd1,
   input  logic                  rsv_en,
   input  logic [AW-1:0]         rsv_a,
   output logic [NREGS-1:0]      busy
);
   logic [XLEN-1:0] rf [NREGS];
   // Port 1 is assigned last so it wins a same-register double write; rf[0] is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NREGS; n++) rf[n] <= '0;
      end else begin
         if (we0 && wa0 != AW'(ZERO_REG)) rf[wa0] <= wd0;
         if (we1 && wa1 != AW'(ZERO_REG)) rf[wa1] <= wd1;
      end
   end
   sr_rf_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk    (clk),
      .rst    (rst),
      .we1    (we1),
      .wa1    (wa1),
      .rsv_en (rsv_en),
      .rsv_a  (rsv_a),
      .busy   (busy)
   );
   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit0, hit1, rhit;
      assign a    = ra[i*AW +: AW];
      assign hit0 = BYPASS && we0 && wa0 == a && a != AW'(ZERO_REG);
      assign hit1 = BYPASS && we1 && wa1 == a && a != AW'(ZERO_REG);
      assign rhit = rsv_en && rsv_a == a;
      assign rd[i*XLEN +: XLEN] = rst ? '0 : hit1 ? wd1 : hit0 ? wd0 : rf[a];
      // A completing port-1 writeback hides the busy bit unless it is re-reserved this cycle.
      assign rbusy[i] = !rst && busy[a] && !(hit1 && !rhit);
   end
endmodule
